parity_check_scheduler: RTL and testbench

//  Shares one registered 9-bit 74x280-style parity checker among NUM_REQ requesters.

---
 rtl/parity_check_scheduler_if.sv | 26 ++
 rtl/parity_check_scheduler.sv | 118 +++++++++++
 tb/tb_parity_check_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/parity_check_scheduler_if.sv
// Handshake bundle between the requesters/result consumer and the shared parity checker.
// The master side is the requesters plus the consumer; the slave side is the scheduler.
interface parity_check_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [9*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 res_valid;
    logic                 res_ready;
    logic [ID_W-1:0]      res_id;
    logic                 res_even;
    logic                 res_odd;
    logic                 res_err;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_id, res_even, res_odd, res_err
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_id, res_even, res_odd, res_err
    );
endinterface

// File: rtl/parity_check_scheduler.sv
// Round-robin scheduler sharing one registered 9-bit 74x280-style parity checker
// among NUM_REQ requesters, with a saturating mismatch counter.
module parity_check_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int ODD_MODE  = 0,
    parameter int ERR_CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    parity_check_scheduler_if.slave       bus,
    input  logic                          err_clr,
    output logic [ERR_CNT_W-1:0]          err_count,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

    localparam logic                 ODD_BIT = (ODD_MODE != 0);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    state_t               state, state_next;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      cand;
    logic [ID_W-1:0]      gnt_id;
    logic                 gnt_found;
    logic [8:0]           gnt_word;
    logic [NUM_REQ-1:0]   gnt_onehot;
    logic [8:0]           word_q;
    logic [ID_W-1:0]      id_q;
    logic [ID_W-1:0]      res_id_q;
    logic                 res_even_q, res_odd_q, res_err_q;
    logic                 take_result;

    // Search upward from the round-robin pointer for the first pending requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
        gnt_word   = bus.req_data[9*int'(gnt_id) +: 9];
        gnt_onehot = '0;
        if (state == IDLE && gnt_found) begin
            gnt_onehot[gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_found) state_next = CHECK;
            CHECK:   state_next = REPORT;
            REPORT:  if (bus.res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result fields are written only in CHECK, so they stay frozen throughout REPORT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            word_q     <= '0;
            id_q       <= '0;
            res_id_q   <= '0;
            res_even_q <= 1'b0;
            res_odd_q  <= 1'b0;
            res_err_q  <= 1'b0;
        end else begin
            if (state == IDLE && gnt_found) begin
                word_q <= gnt_word;
                id_q   <= gnt_id;
                rr_ptr <= ID_W'((int'(gnt_id) + 1) % NUM_REQ);
            end
            if (state == CHECK) begin
                res_even_q <= ~(^word_q);
                res_odd_q  <= ^word_q;
                res_err_q  <= (^word_q) ^ ODD_BIT;
                res_id_q   <= id_q;
            end
        end
    end

    assign take_result = (state == REPORT) && bus.res_ready;

    // Clear has priority over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (take_result && res_err_q && err_count != CNT_MAX) begin
            err_count <= err_count + 1'b1;
        end
    end

    assign bus.req_ready = gnt_onehot;
    assign bus.res_valid = (state == REPORT);
    assign bus.res_id    = res_id_q;
    assign bus.res_even  = res_even_q;
    assign bus.res_odd   = res_odd_q;
    assign bus.res_err   = res_err_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_parity_check_scheduler.sv
// Self-checking bench for parity_check_scheduler: directed scenarios followed by
// random traffic, all compared against a round-robin/parity reference model.
module tb_parity_check_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int ID_W      = 2;
    localparam int ERR_CNT_W = 2;
    localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic errClr;
    logic [ERR_CNT_W-1:0] errCount;
    logic busy;

    int checks = 0;
    int errors = 0;
    int modelRr = 0;
    int modelErr = 0;

    always #5 clk = ~clk;

    parity_check_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    parity_check_scheduler #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ODD_MODE(0), .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .err_clr(errClr), .err_count(errCount), .busy(busy)
    );

    function automatic int pickGrant(input logic [NUM_REQ-1:0] valid, input int rr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (valid[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [9*NUM_REQ-1:0] data,
                                 input logic resReady, input logic clr);
        bus.req_valid = valid;
        bus.req_data  = data;
        bus.res_ready = resReady;
        errClr        = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkFields(input int g, input int p);
        checkOutput("resValid", 32'(bus.res_valid), 32'd1);
        checkOutput("resId", 32'(bus.res_id), 32'(g));
        checkOutput("resEven", 32'(bus.res_even), 32'(1 - p));
        checkOutput("resOdd", 32'(bus.res_odd), 32'(p));
        checkOutput("resErr", 32'(bus.res_err), 32'(p));
        checkOutput("reportReady", 32'(bus.req_ready), 32'd0);
    endtask

    task automatic idleCycle();
        applyStimulus('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("idleNoGrant", 32'(bus.req_ready), 32'd0);
        checkOutput("idleBusy", 32'(busy), 32'd0);
        checkOutput("idleValid", 32'(bus.res_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    // One complete word: grant in IDLE, CHECK, then REPORT held for 'hold' cycles before the handshake.
    task automatic runWord(input logic [NUM_REQ-1:0] valid, input logic [9*NUM_REQ-1:0] data,
                           input int hold, input logic clr);
        int g;
        int p;
        logic [8:0] w;
        g = pickGrant(valid, modelRr);
        w = data[9*g +: 9];
        p = $countones(w) % 2;
        applyStimulus(valid, data, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("grant", 32'(bus.req_ready), 32'(1 << g));
        checkOutput("grantBusy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("checkReady", 32'(bus.req_ready), 32'd0);
        checkOutput("checkValid", 32'(bus.res_valid), 32'd0);
        checkOutput("checkBusy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkFields(g, p);
            @(posedge clk); #1;
        end
        applyStimulus(valid, data, 1'b1, clr);
        @(negedge clk);
        checkFields(g, p);
        @(posedge clk); #1;
        if (clr) modelErr = 0;
        else if (p == 1 && modelErr < ERR_MAX) modelErr++;
        modelRr = (g + 1) % NUM_REQ;
        checkOutput("errCount", 32'(errCount), 32'(modelErr));
        checkOutput("doneBusy", 32'(busy), 32'd0);
        applyStimulus('0, data, 1'b0, 1'b0);
    endtask

    initial begin
        logic [9*NUM_REQ-1:0] rdata;
        logic [NUM_REQ-1:0] rvalid;

        rst = 1'b1;
        applyStimulus('0, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rstReady", 32'(bus.req_ready), 32'd0);
        checkOutput("rstValid", 32'(bus.res_valid), 32'd0);
        checkOutput("rstId", 32'(bus.res_id), 32'd0);
        checkOutput("rstEven", 32'(bus.res_even), 32'd0);
        checkOutput("rstOdd", 32'(bus.res_odd), 32'd0);
        checkOutput("rstErr", 32'(bus.res_err), 32'd0);
        checkOutput("rstCount", 32'(errCount), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idleCycle();

        $display("[TB] zero word from requester 0");
        runWord(4'b0001, '0, 0, 1'b0);

        $display("[TB] odd-weight word from requester 2");
        runWord(4'b0100, {9'h000, 9'h155, 9'h000, 9'h000}, 0, 1'b0);

        $display("[TB] all requesters pending, consumer always ready");
        for (int i = 0; i < 5; i++) begin
            runWord(4'b1111, 36'({$urandom(), $urandom()}), 0, 1'b0);
        end

        $display("[TB] consumer stalls for five cycles");
        runWord(4'b1011, 36'({$urandom(), $urandom()}), 5, 1'b0);

        $display("[TB] counter saturation and clear priority");
        errClr = 1'b1;
        @(posedge clk); #1;
        errClr = 1'b0;
        modelErr = 0;
        checkOutput("clrIdle", 32'(errCount), 32'd0);
        for (int i = 0; i < 5; i++) begin
            runWord(4'b0010, {4{9'h1FF}}, 0, 1'b0);
        end
        runWord(4'b0010, {4{9'h1FF}}, 0, 1'b1);

        $display("[TB] reset while checking");
        runWord(4'b0100, 36'({$urandom(), $urandom()}), 0, 1'b0);
        applyStimulus(4'b0100, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("midRstValid", 32'(bus.res_valid), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstCount", 32'(errCount), 32'd0);
        applyStimulus('0, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        modelRr = 0;
        modelErr = 0;
        runWord(4'b1111, 36'({$urandom(), $urandom()}), 0, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idleCycle();
            end else begin
                rvalid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
                rdata  = 36'({$urandom(), $urandom()});
                runWord(rvalid, rdata, int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
